// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory port to Wishbone B4 pipelined master bridge.
// One transaction in flight at a time, with bus-error reporting and a response watchdog.
module urv_dm_wb_bridge #(
  parameter int unsigned g_timeout  = 1023,
  parameter logic [31:0] g_err_data = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,

  output logic        bus_err_o,
  output logic [31:0] bus_err_addr_o
);

  // The counter only has to reach g_timeout-1: the timeout fires on the
  // cycle in which the count would step onto g_timeout.
  localparam int unsigned CW = (g_timeout > 1) ? $clog2(g_timeout) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(g_timeout - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state_q;
  logic          cyc_q;
  logic          stb_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  logic          ready_q;
  logic [31:0]   data_l_q;
  logic          load_done_q;
  logic          store_done_q;
  logic          bus_err_q;
  logic [31:0]   bus_err_addr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic resp_ok;
  logic got_err;
  logic got_ack;
  logic tmo;
  logic fault;
  logic done;
  logic accept;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^dm_addr_i[1:0];

  // A response only counts once the strobe has been taken by the slave.
  assign resp_ok = (state_q == S_WAIT) || ((state_q == S_REQ) && !wb_stall_i);
  assign got_err = resp_ok && wb_err_i;
  assign got_ack = resp_ok && wb_ack_i && !wb_err_i;
  assign tmo     = (g_timeout != 0) && (state_q != S_IDLE) && (cnt_q == TO_LAST);
  assign fault   = got_err || (tmo && !got_ack);
  assign done    = got_ack || fault;
  assign accept  = ready_q && (dm_load_i || dm_store_i);
  assign cnt_d   = cnt_q + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cyc_q          <= 1'b0;
      stb_q          <= 1'b0;
      we_q           <= 1'b0;
      adr_q          <= 32'h0;
      sel_q          <= 4'h0;
      dat_q          <= 32'h0;
      ready_q        <= 1'b1;
      data_l_q       <= 32'h0;
      load_done_q    <= 1'b0;
      store_done_q   <= 1'b0;
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= 32'h0;
      cnt_q          <= '0;
    end else begin
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            adr_q   <= {dm_addr_i[31:2], 2'b00};
            dat_q   <= dm_data_s_i;
            sel_q   <= dm_data_select_i;
            we_q    <= dm_store_i;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          cnt_q <= cnt_d;
          if (done) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
            if (we_q) begin
              store_done_q <= 1'b1;
            end else begin
              load_done_q <= 1'b1;
              data_l_q    <= fault ? g_err_data : wb_dat_i;
            end
            if (fault) begin
              bus_err_q      <= 1'b1;
              bus_err_addr_q <= adr_q;
            end
          end else if ((state_q == S_REQ) && !wb_stall_i) begin
            stb_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dm_ready_o      = ready_q;
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign wb_cyc_o        = cyc_q;
  assign wb_stb_o        = stb_q;
  assign wb_we_o         = we_q;
  assign wb_adr_o        = adr_q;
  assign wb_sel_o        = sel_q;
  assign wb_dat_o        = dat_q;
  assign bus_err_o       = bus_err_q;
  assign bus_err_addr_o  = bus_err_addr_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Directed bench for urv_dm_wb_bridge; completions are checked by a
// scoreboard monitor fed with expected responses at request time.
module tb_urv_dm_wb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] dm_addr_i = 32'h0;
  logic [31:0] dm_data_s_i = 32'h0;
  logic [3:0]  dm_data_select_i = 4'h0;
  logic        dm_store_i = 1'b0;
  logic        dm_load_i = 1'b0;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_stall_i = 1'b0;
  logic        bus_err_o;
  logic [31:0] bus_err_addr_o;

  localparam logic [31:0] ERR_DATA = 32'hDEAD0BAD;

  urv_dm_wb_bridge #(
    .g_timeout (8),
    .g_err_data(ERR_DATA)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .dm_addr_i       (dm_addr_i),
    .dm_data_s_i     (dm_data_s_i),
    .dm_data_select_i(dm_data_select_i),
    .dm_store_i      (dm_store_i),
    .dm_load_i       (dm_load_i),
    .dm_ready_o      (dm_ready_o),
    .dm_data_l_o     (dm_data_l_o),
    .dm_load_done_o  (dm_load_done_o),
    .dm_store_done_o (dm_store_done_o),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_we_o         (wb_we_o),
    .wb_adr_o        (wb_adr_o),
    .wb_sel_o        (wb_sel_o),
    .wb_dat_o        (wb_dat_o),
    .wb_dat_i        (wb_dat_i),
    .wb_ack_i        (wb_ack_i),
    .wb_err_i        (wb_err_i),
    .wb_stall_i      (wb_stall_i),
    .bus_err_o       (bus_err_o),
    .bus_err_addr_o  (bus_err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic is_load, input logic [31:0] data,
                      input logic err, input logic [31:0] addr);
    exp_t e;
    e.is_load = is_load;
    e.data    = data;
    e.err     = err;
    e.addr    = addr;
    sb.push_back(e);
  endtask

  // Any completion or error pulse must match the oldest expected response.
  always @(negedge clk_i) begin
    if (!rst_i && (dm_load_done_o || dm_store_done_o || bus_err_o)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_response: got load_done=%0b store_done=%0b bus_err=%0b expected none (t=%0t)",
                 dm_load_done_o, dm_store_done_o, bus_err_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_load_done", {31'h0, dm_load_done_o}, {31'h0, e.is_load});
        chk("mon_store_done", {31'h0, dm_store_done_o}, {31'h0, !e.is_load});
        chk("mon_bus_err", {31'h0, bus_err_o}, {31'h0, e.err});
        if (e.is_load) chk("mon_load_data", dm_data_l_o, e.data);
        if (e.err) chk("mon_err_addr", bus_err_addr_o, e.addr);
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel);
    dm_load_i        = ld;
    dm_store_i       = st;
    dm_addr_i        = addr;
    dm_data_s_i      = data;
    dm_data_select_i = sel;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ready", {31'h0, dm_ready_o}, 32'h1);
    chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    chk("rst_done", {30'h0, dm_load_done_o, dm_store_done_o}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err_o}, 32'h0);
    chk("rst_err_addr", bus_err_addr_o, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_data_l", dm_data_l_o, 32'h0);
    rst_i = 1'b0;
    tick();

    // Zero-wait load
    issue(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'b1111);
    push(1'b1, 32'hCAFEBABE, 1'b0, 32'h0);
    tick();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("ld_stb_c1", {31'h0, wb_stb_o}, 32'h1);
    chk("ld_cyc_c1", {31'h0, wb_cyc_o}, 32'h1);
    chk("ld_adr", wb_adr_o, 32'h1000_0004);
    chk("ld_we", {31'h0, wb_we_o}, 32'h0);
    chk("ld_sel", {28'h0, wb_sel_o}, 32'hF);
    chk("ld_ready_c1", {31'h0, dm_ready_o}, 32'h0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFEBABE;
    tick();
    wb_ack_i = 1'b0;
    chk("ld_done_c2", {31'h0, dm_load_done_o}, 32'h1);
    chk("ld_ready_c2", {31'h0, dm_ready_o}, 32'h1);
    chk("ld_cyc_c2", {31'h0, wb_cyc_o}, 32'h0);
    tick();

    // Store: stall for 3 cycles, strobe taken on 4th, ack 2 cycles later
    issue(1'b0, 1'b1, 32'h1000_000B, 32'h1122_3344, 4'b0011);
    push(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("st_stb_held", {31'h0, wb_stb_o}, 32'h1);
      chk("st_adr_held", wb_adr_o, 32'h1000_0008);
      chk("st_dat_held", wb_dat_o, 32'h1122_3344);
      chk("st_sel_held", {28'h0, wb_sel_o}, 32'h3);
      chk("st_we", {31'h0, wb_we_o}, 32'h1);
      wb_stall_i = (i < 3);
      tick();
    end
    wb_stall_i = 1'b0;
    chk("st_stb_dropped", {31'h0, wb_stb_o}, 32'h0);
    chk("st_cyc_wait", {31'h0, wb_cyc_o}, 32'h1);
    tick();
    chk("st_no_early_done", {31'h0, dm_store_done_o}, 32'h0);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("st_done", {31'h0, dm_store_done_o}, 32'h1);
    chk("st_no_load_done", {31'h0, dm_load_done_o}, 32'h0);
    tick();

    // Bus error on a load
    issue(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF);
    push(1'b1, ERR_DATA, 1'b1, 32'h2000_0000);
    tick();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_err_i = 1'b1;
    tick();
    wb_err_i = 1'b0;
    chk("err_pulse", {31'h0, bus_err_o}, 32'h1);
    chk("err_addr", bus_err_addr_o, 32'h2000_0000);
    tick();
    chk("err_pulse_one", {31'h0, bus_err_o}, 32'h0);
    chk("err_addr_hold", bus_err_addr_o, 32'h2000_0000);

    // Watchdog with a silent slave: done 8 cycles after entering REQ
    issue(1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
    push(1'b1, ERR_DATA, 1'b1, 32'h3000_0010);
    tick();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      chk("tmo_cyc_busy", {31'h0, wb_cyc_o}, 32'h1);
      chk("tmo_no_done", {31'h0, dm_load_done_o}, 32'h0);
      tick();
    end
    chk("tmo_done", {31'h0, dm_load_done_o}, 32'h1);
    chk("tmo_bus_err", {31'h0, bus_err_o}, 32'h1);
    chk("tmo_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
    issue(1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'hF);
    push(1'b1, 32'h5A5A_5A5A, 1'b0, 32'h0);
    tick();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h5A5A_5A5A;
    tick();
    wb_ack_i = 1'b0;
    chk("post_tmo_done", {31'h0, dm_load_done_o}, 32'h1);
    tick();

    // Simultaneous strobes (store wins), then back-to-back load
    issue(1'b1, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF);
    push(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    issue(1'b1, 1'b0, 32'h4000_0100, 32'h0, 4'hF);
    chk("both_we", {31'h0, wb_we_o}, 32'h1);
    chk("both_dat", wb_dat_o, 32'hDEAD_BEEF);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("b2b_store_done", {31'h0, dm_store_done_o}, 32'h1);
    issue(1'b1, 1'b0, 32'h4000_0004, 32'h0, 4'h5);
    push(1'b1, 32'h0102_0304, 1'b0, 32'h0);
    tick();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("b2b_stb_no_gap", {31'h0, wb_stb_o}, 32'h1);
    chk("b2b_adr", wb_adr_o, 32'h4000_0004);
    chk("b2b_we", {31'h0, wb_we_o}, 32'h0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0102_0304;
    tick();
    wb_ack_i = 1'b0;
    chk("b2b_load_done", {31'h0, dm_load_done_o}, 32'h1);
    tick();

    // Reset during WAIT, then a stray ack
    issue(1'b0, 1'b1, 32'h5000_0000, 32'h7777_7777, 4'hF);
    tick();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rw_in_wait", {30'h0, wb_cyc_o, wb_stb_o}, 32'h2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rw_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rw_ready", {31'h0, dm_ready_o}, 32'h1);
    chk("rw_no_done", {30'h0, dm_load_done_o, dm_store_done_o}, 32'h0);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("stray_no_done", {30'h0, dm_load_done_o, dm_store_done_o}, 32'h0);
    chk("stray_cyc", {31'h0, wb_cyc_o}, 32'h0);
    repeat (3) tick();

    chk("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/urv_dm_wb_bridge.md
Name: urv_dm_wb_bridge

Overview:
- Sits directly downstream of the uRV CPU data-memory port and consumes its load/store requests (address, store data, byte selects, load/store strobes).
- Issues each request as a single Wishbone B4 pipelined master transaction.
- Returns load data and load/store completion pulses to the CPU's writeback path.
- Supports one outstanding transaction at a time, with a bus-error path and a watchdog timeout.

Parameters:
g_timeout, 1023, number of cycles to wait for ack/err after cyc_o rises before aborting; 0 disables the watchdog.
g_err_data, 32'h00000000, load data returned on an error or timeout.

Ports:
clk_i  in  1  system clock; every flop is on the rising edge.
rst_i  in  1  synchronous reset, active-high.
dm_addr_i  in  32  CPU request byte address.
dm_data_s_i  in  32  CPU store data.
dm_data_select_i  in  4  CPU byte lane selects.
dm_store_i  in  1  store request strobe.
dm_load_i  in  1  load request strobe.
dm_ready_o  out  1  bridge idle; a request is accepted only while this is high.
dm_data_l_o  out  32  load data; valid only while dm_load_done_o is high.
dm_load_done_o  out  1  one-cycle load completion pulse.
dm_store_done_o  out  1  one-cycle store completion pulse.
wb_cyc_o  out  1  Wishbone cycle.
wb_stb_o  out  1  Wishbone strobe.
wb_we_o  out  1  write enable.
wb_adr_o  out  32  Wishbone address; equals dm_addr_i with bits [1:0] forced to 0.
wb_sel_o  out  4  byte selects.
wb_dat_o  out  32  write data.
wb_dat_i  in  32  read data.
wb_ack_i  in  1  acknowledge.
wb_err_i  in  1  bus error.
wb_stall_i  in  1  pipelined stall.
bus_err_o  out  1  one-cycle pulse on a bus error or timeout.
bus_err_addr_o  out  32  address of the last faulting access; holds its value until the next fault.

Behaviour:
- Reset values:
  - All outputs are 0 except dm_ready_o=1.
  - The FSM is in IDLE and the timeout counter is 0.
  - Reset asserted mid-transaction drops cyc/stb at the next edge; no done pulse is emitted.
- Request acceptance:
  - Accept when dm_ready_o && (dm_load_i || dm_store_i).
  - At acceptance, register addr, data, sel and we; we=dm_store_i.
  - If dm_load_i and dm_store_i are both high, the store wins and the load is dropped.
  - Strobes seen while dm_ready_o=0 are ignored.
- FSM states:
  - IDLE: cyc=0, stb=0, ready=1. On accept, go to REQ the next cycle.
  - REQ: cyc=1, stb=1, ready=0. While wb_stall_i=1, stay and hold every bus output stable. When wb_stall_i=0, the strobe is accepted; go to WAIT unless ack or err arrives in the same cycle, in which case complete directly.
  - WAIT: cyc=1, stb=0. Remain here until ack, err or timeout.
  - Completion, on any of ack, err or timeout:
    - Registered: at the next edge cyc=0, stb=0, ready=1 and the FSM is back in IDLE.
    - The matching dm_*_done_o pulses for exactly that one cycle.
    - On ack, dm_data_l_o=wb_dat_i, captured in the ack cycle.
    - On err or timeout, dm_data_l_o=g_err_data and bus_err_o pulses together with the done pulse.
    - bus_err_addr_o captures the faulting address.
- Latency with zero-wait slave (stall=0, ack in the same cycle as stb), counting the accept cycle as 0:
  - stb high in cycle 1.
  - done pulse in cycle 2.
  - dm_ready_o high again in cycle 2, so a back-to-back request is accepted in cycle 2.
- Timeout:
  - The counter clears on entering REQ and increments every cycle in REQ or WAIT.
  - When the count reaches g_timeout with no ack/err in that cycle, complete as an error.
  - Ack or err arriving in the same cycle as the timeout takes priority over the timeout.
- Priority: err and ack in the same cycle is treated as err.
- Stray signals: ack/err received in IDLE are ignored and produce no done pulse.
- dm_ready_o is registered and has no combinational path from any Wishbone input.
- dm_load_done_o and dm_store_done_o are never high together.
- Data formatting: no byte steering; sel and data pass through unchanged. The CPU performs lane alignment and sign extension.

Test Plan:
- Load with zero-wait slave: addr 0x1000_0004, slave returns 0xCAFEBABE with ack in the stb cycle -> wb_adr_o=0x10000004, we=0, sel as driven; dm_load_done_o and dm_data_l_o=0xCAFEBABE in cycle 2; ready back in cycle 2.
- Store with stall 3 cycles then ack 2 cycles later: data 0x11223344, sel 4'b0011 -> stb held for 4 cycles with constant adr/dat/sel; dm_store_done_o pulses once, 1 cycle after ack; no load_done.
- Bus error: load to 0x2000_0000 with slave asserting err -> dm_load_done_o with data=g_err_data; bus_err_o one pulse; bus_err_addr_o=0x20000000.
- Timeout with g_timeout=8 and silent slave -> done pulse plus bus_err_o exactly 8 cycles after entering REQ; cyc drops; a subsequent load completes normally.
- Simultaneous load and store strobes; then back-to-back requests -> store executed (we=1), no load done; second request accepted the same cycle as the first done, with no idle gap.
- rst_i asserted during WAIT; a stray ack after reset -> cyc=0 next edge, ready=1, no done pulses from either the reset or the stray ack.
